weight_update_engine: RTL and testbench

Streaming, lane-parallel weight-update unit for the training datapath, the sequential successor to the combinational weight add. Per update pass it consumes DEPTH old weights and DEPTH deltas/gradients, LANES elements per beat. It produces saturated new weights in one of two modes: plain accumulate (w_old + delta) or scaled SGD step (w_old − lr·grad). It sits between the gradient/delta stage and the weight memory write-back port. Valid/ready handshakes on both sides, a fixed 2-stage pipeline, and a done pulse per pass.

---
 rtl/weight_update_engine.sv | 181 ++++++++++++++++++
 tb/tb_weight_update_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_engine.sv
// Streaming lane-parallel weight update: saturated accumulate or fixed-point SGD step,
// two-stage valid/ready pipeline that emits a one-cycle done pulse on the last beat of a pass.
module weight_update_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic [DATA_W-1:0]       i_lr,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [LANES*DATA_W-1:0] i_w_old,
  input  logic [LANES*DATA_W-1:0] i_delta,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [LANES*DATA_W-1:0] o_w_new,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned BEATS  = DEPTH / LANES;
  localparam int unsigned CNT_W  = $clog2(BEATS + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // step is clamped to DATA_W+1 bits before the subtraction
  localparam logic signed [PROD_W-1:0] STEP_MAX = {{(PROD_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [PROD_W-1:0] STEP_MIN = {{(PROD_W - DATA_W){1'b1}}, {DATA_W{1'b0}}};

  localparam logic signed [DATA_W+1:0] RES_MAX = {3'b000, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W+1:0] RES_MIN = {3'b111, {(DATA_W - 1){1'b0}}};

  function automatic logic [DATA_W-1:0] sat_data(input logic signed [DATA_W+1:0] v);
    logic [DATA_W+1:0] clamped;
    if (v > RES_MAX) begin
      clamped = RES_MAX;
    end else if (v < RES_MIN) begin
      clamped = RES_MIN;
    end else begin
      clamped = v;
    end
    return clamped[DATA_W-1:0];
  endfunction

  // Control state
  logic [0:0]        r_state;
  logic [0:0]        w_state_d;
  logic              r_mode;
  logic [DATA_W-1:0] r_lr;
  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  r_out_cnt;

  // Pipeline state
  logic                     r_s1_valid;
  logic [DATA_W-1:0]        r_s1_w  [LANES];
  logic signed [PROD_W-1:0] r_s1_op [LANES];
  logic                     r_s2_valid;
  logic [LANES*DATA_W-1:0]  r_w_new;

  // Datapath wires
  logic                     w_stall;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_last;
  logic                     w_start;
  logic signed [PROD_W-1:0] w_lr_ext;
  logic signed [PROD_W-1:0] w_d_ext   [LANES];
  logic signed [PROD_W-1:0] w_s1_op_d [LANES];
  logic signed [PROD_W-1:0] w_shift   [LANES];
  logic signed [DATA_W:0]   w_step    [LANES];
  logic signed [DATA_W:0]   w_sum     [LANES];
  logic signed [DATA_W+1:0] w_pre     [LANES];
  logic [LANES*DATA_W-1:0]  w_w_new_d;

  assign w_stall    = r_s2_valid && !i_out_ready;
  assign o_in_ready = (r_state == S_RUN) && (r_in_cnt < ALL_BEATS) && !w_stall;
  assign w_in_fire  = i_in_valid && o_in_ready;
  assign w_out_fire = r_s2_valid && i_out_ready;
  assign w_last     = w_out_fire && (r_state == S_RUN) && (r_out_cnt == LAST_BEAT);
  assign w_start    = (r_state == S_IDLE) && i_start;

  assign o_out_valid = r_s2_valid;
  assign o_w_new     = r_w_new;
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = w_last;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_d = S_RUN;
      S_RUN:   if (w_last) w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  // Stage 1 operand: full-width product in SGD mode, sign-extended delta otherwise
  always_comb begin
    w_lr_ext = $signed({{DATA_W{r_lr[DATA_W-1]}}, r_lr});
    for (int i = 0; i < LANES; i++) begin
      w_d_ext[i] = $signed({{DATA_W{i_delta[i*DATA_W+DATA_W-1]}}, i_delta[i*DATA_W +: DATA_W]});
      if (r_mode) begin
        w_s1_op_d[i] = w_lr_ext * w_d_ext[i];
      end else begin
        w_s1_op_d[i] = w_d_ext[i];
      end
    end
  end

  // Stage 2 result: floor-shifted, clamped step or plain sum, then clamp to DATA_W
  always_comb begin
    w_w_new_d = '0;
    for (int i = 0; i < LANES; i++) begin
      w_shift[i] = r_s1_op[i] >>> FRAC_W;
      if (w_shift[i] > STEP_MAX) begin
        w_step[i] = STEP_MAX[DATA_W:0];
      end else if (w_shift[i] < STEP_MIN) begin
        w_step[i] = STEP_MIN[DATA_W:0];
      end else begin
        w_step[i] = w_shift[i][DATA_W:0];
      end
      w_sum[i] = {r_s1_w[i][DATA_W-1], r_s1_w[i]}
               + {r_s1_op[i][DATA_W-1], r_s1_op[i][DATA_W-1:0]};
      if (r_mode) begin
        w_pre[i] = {{2{r_s1_w[i][DATA_W-1]}}, r_s1_w[i]} - {w_step[i][DATA_W], w_step[i]};
      end else begin
        w_pre[i] = {w_sum[i][DATA_W], w_sum[i]};
      end
      w_w_new_d[i*DATA_W +: DATA_W] = sat_data(w_pre[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_lr       <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_w_new    <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_w[i]  <= '0;
        r_s1_op[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_mode    <= i_mode;
        r_lr      <= i_lr;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_fire) r_in_cnt <= r_in_cnt + CNT_W'(1);
        if (w_out_fire) r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
      // Both stages advance together; a stall freezes the whole pipe
      if (!w_stall) begin
        r_s1_valid <= w_in_fire;
        if (w_in_fire) begin
          for (int i = 0; i < LANES; i++) begin
            r_s1_w[i]  <= i_w_old[i*DATA_W +: DATA_W];
            r_s1_op[i] <= w_s1_op_d[i];
          end
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_w_new <= w_w_new_d;
      end
    end
  end

endmodule

// File: tb/tb_weight_update_engine.sv
// Bench for weight_update_engine: constant-vector table passes, hand-built corner passes
// (backpressure, mid-pass reset, start during RUN) and random passes against an arithmetic model.
module tb_weight_update_engine;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DEPTH  = 64;
  localparam int          BEATS  = DEPTH / LANES;
  localparam int          BUS_W  = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] lr;
  logic              in_valid;
  logic              in_ready;
  logic [BUS_W-1:0]  w_old;
  logic [BUS_W-1:0]  delta;
  logic              out_valid;
  logic              out_ready;
  logic [BUS_W-1:0]  w_new;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  logic [BUS_W-1:0] beat_w   [BEATS];
  logic [BUS_W-1:0] beat_d   [BEATS];
  logic [BUS_W-1:0] beat_exp [BEATS];

  typedef struct {
    bit                mode;
    logic [DATA_W-1:0] lr;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  weight_update_engine #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_mode      (mode),
    .i_lr        (lr),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_w_old     (w_old),
    .i_delta     (delta),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_w_new     (w_new),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: real-valued fixed-point rules with floor division and clamps
  function automatic logic [DATA_W-1:0] model_lane(input bit m, input logic [DATA_W-1:0] l,
                                                   input logic [DATA_W-1:0] w,
                                                   input logic [DATA_W-1:0] d);
    longint wi, di, li, prod, step, r, scale;
    wi    = $signed(w);
    di    = $signed(d);
    li    = $signed(l);
    scale = longint'(1) << FRAC_W;
    if (!m) begin
      r = wi + di;
    end else begin
      prod = li * di;
      step = prod / scale;
      if (prod < 0 && (prod % scale) != 0) step = step - 1;
      if (step > 65535) step = 65535;
      if (step < -65536) step = -65536;
      r = wi - step;
    end
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[DATA_W-1:0];
  endfunction

  task automatic fill_const(input vec_t v);
    for (int b = 0; b < BEATS; b++) begin
      for (int ln = 0; ln < LANES; ln++) begin
        beat_w[b][ln*DATA_W +: DATA_W]   = v.w;
        beat_d[b][ln*DATA_W +: DATA_W]   = v.d;
        beat_exp[b][ln*DATA_W +: DATA_W] = v.exp;
      end
    end
  endtask

  task automatic fill_random(input bit m, input logic [DATA_W-1:0] l);
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] g;
    for (int b = 0; b < BEATS; b++) begin
      for (int ln = 0; ln < LANES; ln++) begin
        a = DATA_W'($urandom);
        g = DATA_W'($urandom);
        beat_w[b][ln*DATA_W +: DATA_W]   = a;
        beat_d[b][ln*DATA_W +: DATA_W]   = g;
        beat_exp[b][ln*DATA_W +: DATA_W] = model_lane(m, l, a, g);
      end
    end
  endtask

  // bp: 0 = always ready, 1 = 5-cycle stall window, 2 = random stalls
  task automatic run_pass(input string tag, input bit m, input logic [DATA_W-1:0] l,
                          input int bp, input bit hold, input int rst_at, input bit restart);
    int in_idx = 0;
    int out_idx = 0;
    int done_cnt = 0;
    int first_acc = -1;
    int first_ov = -1;
    int cyc = 0;
    bit prev_stall = 1'b0;
    bit finished = 1'b0;
    logic [BUS_W-1:0] held = '0;

    @(negedge clk);
    start = 1'b1; mode = m; lr = l; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check({tag, " busy_before_start"}, 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, " busy_after_start"}, 64'(busy), 64'd1);
    check({tag, " in_ready_after_start"}, 64'(in_ready), 64'd1);

    while (!finished && cyc < 400) begin
      if (rst_at >= 0 && in_idx == rst_at) begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, " rst_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " rst_busy"}, 64'(busy), 64'd0);
        check({tag, " rst_done"}, 64'(done), 64'd0);
        check({tag, " rst_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " rst_no_done_before"}, 64'(done_cnt), 64'd0);
        return;
      end
      case (bp)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= 6 && cyc < 11);
        default: out_ready = ($urandom_range(0, 99) >= 30);
      endcase
      if (restart && cyc == 3) begin
        start = 1'b1; mode = ~m; lr = l ^ 16'h5A5A;
      end else begin
        start = 1'b0;
      end
      in_valid = (in_idx < BEATS) || hold;
      w_old = beat_w[(in_idx < BEATS) ? in_idx : BEATS - 1];
      delta = beat_d[(in_idx < BEATS) ? in_idx : BEATS - 1];
      #1;
      if (prev_stall) begin
        check({tag, " stall_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, " stall_hold_data"}, 64'(w_new), 64'(held));
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        check({tag, " stall_in_ready"}, 64'(in_ready), 64'd0);
        held = w_new;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        in_idx++;
      end
      if (out_valid && first_ov < 0) begin
        first_ov = cyc;
        check({tag, " latency"}, 64'(first_ov - first_acc), 64'd2);
      end
      if (out_valid && out_ready) begin
        check($sformatf("%s beat%0d", tag, out_idx), 64'(w_new), 64'(beat_exp[out_idx]));
        if (done) begin
          done_cnt++;
          check({tag, " done_on_last"}, 64'(out_idx), 64'(BEATS - 1));
        end
        out_idx++;
        if (out_idx == BEATS) finished = 1'b1;
      end else if (done) begin
        check({tag, " spurious_done"}, 64'(done), 64'd0);
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) check({tag, " timeout_out_beats"}, 64'(out_idx), 64'(BEATS));
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " accept_count"}, 64'(in_idx), 64'(BEATS));
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] rl;
    bit                rm;

    vecs[0] = '{mode: 1'b1, lr: 16'h0080, w: 16'h0100, d: 16'h0200, exp: 16'h0000};
    vecs[1] = '{mode: 1'b0, lr: 16'h0000, w: 16'h7F00, d: 16'h0200, exp: 16'h7FFF};
    vecs[2] = '{mode: 1'b0, lr: 16'h0000, w: 16'h8100, d: 16'hFE00, exp: 16'h8000};
    vecs[3] = '{mode: 1'b0, lr: 16'h0000, w: 16'h0010, d: 16'hFFF0, exp: 16'h0000};
    vecs[4] = '{mode: 1'b1, lr: 16'h0001, w: 16'h0005, d: 16'hFFFF, exp: 16'h0006};
    vecs[5] = '{mode: 1'b1, lr: 16'h7FFF, w: 16'h7000, d: 16'h8000, exp: 16'h7FFF};
    vecs[6] = '{mode: 1'b1, lr: 16'h0100, w: 16'h8000, d: 16'h0300, exp: 16'h8000};

    rst = 1'b1; start = 1'b0; mode = 1'b0; lr = '0; in_valid = 1'b0;
    w_old = '0; delta = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset w_new", 64'(w_new), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      fill_const(vecs[i]);
      run_pass($sformatf("vec%0d", i), vecs[i].mode, vecs[i].lr, 0, 1'b0, -1, 1'b0);
    end

    fill_random(1'b0, 16'h0000);
    run_pass("backpressure", 1'b0, 16'h0000, 1, 1'b1, -1, 1'b0);

    fill_random(1'b1, 16'h0040);
    run_pass("reset_mid", 1'b1, 16'h0040, 0, 1'b0, 7, 1'b0);
    run_pass("after_reset", 1'b1, 16'h0040, 0, 1'b0, -1, 1'b0);

    fill_random(1'b1, 16'h0123);
    run_pass("restart_ignored", 1'b1, 16'h0123, 0, 1'b0, -1, 1'b1);

    for (int p = 0; p < 4; p++) begin
      rm = p[0];
      rl = (p < 2) ? DATA_W'($urandom_range(0, 511)) : DATA_W'($urandom);
      fill_random(rm, rl);
      run_pass($sformatf("rand%0d", p), rm, rl, 2, p[1], -1, 1'b0);
    end

    @(negedge clk);
    #1;
    check("final busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
